// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers: fixed-latency mult/div sequencing,
// mthi/mtlo writes and a stall request for dependent D-stage instructions.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_in_d,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;

    logic [63:0]        product;
    logic [31:0]        divisor;
    logic [31:0]        num_mag;
    logic [31:0]        den_mag;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;
    logic [31:0]        quot;
    logic [31:0]        rem;
    logic               is_signed;

    // Result datapath on latched operands; division works on magnitudes so
    // 0x80000000 / -1 wraps to 0x80000000 without signed-overflow ambiguity.
    always_comb begin
        is_signed = ~op_q[0];
        product   = '0;
        if (op_q[0]) begin
            product = {32'd0, a_q} * {32'd0, b_q};
        end else begin
            product = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        end
        divisor = (b_q == 32'd0) ? 32'd1 : b_q;
        num_mag = (is_signed && a_q[31])    ? (~a_q + 32'd1)    : a_q;
        den_mag = (is_signed && divisor[31]) ? (~divisor + 32'd1) : divisor;
        q_mag   = num_mag / den_mag;
        r_mag   = num_mag % den_mag;
        quot    = (is_signed && (a_q[31] ^ divisor[31])) ? (~q_mag + 32'd1) : q_mag;
        rem     = (is_signed && a_q[31]) ? (~r_mag + 32'd1) : r_mag;
    end

    assign stall_md = md_in_d & (start | busy);

    // Control FSM, operand latches and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            cnt    <= '0;
            op_q   <= 2'b00;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            hi_out <= 32'd0;
            lo_out <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= rs_val;
                        b_q   <= rt_val;
                        op_q  <= md_op;
                        cnt   <= md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        if (hi_we) hi_out <= rs_val;
                        if (lo_we) lo_out <= rs_val;
                    end
                end
                RUN: begin
                    if (cnt <= CNT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        if (!op_q[1]) begin
                            hi_out <= product[63:32];
                            lo_out <= product[31:0];
                        end else if (b_q != 32'd0) begin
                            hi_out <= rem;
                            lo_out <= quot;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: scoreboard of expected HI/LO per issued op,
// popped when busy falls; reference model uses 64-bit longint arithmetic.
module tb_md_unit;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_in_d;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb_q[$];
    int          total;
    int          bad;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_op   (md_op),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .md_in_d (md_in_d),
        .busy    (busy),
        .stall_md(stall_md),
        .hi_out  (hi_out),
        .lo_out  (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: updates m_hi/m_lo as the architecture defines.
    task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; end
            2'b01: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
            2'b10: if (b != 32'd0) begin
                sq = sa / sb; sr = sa % sb;
                m_hi = sr[31:0]; m_lo = sq[31:0];
            end
            default: if (b != 32'd0) begin
                m_hi = a % b; m_lo = a / b;
            end
        endcase
    endtask

    // Issue one op, push its expectation, then wait (bounded) for busy to drop.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic din, input logic we);
        int   n;
        int   need;
        exp_t e;
        start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        md_in_d = din; hi_we = we; lo_we = we;
        #1;
        check("stall_issue", {31'd0, stall_md}, {31'd0, din});
        model_op(op, a, b);
        sb_q.push_back('{hi: m_hi, lo: m_lo});
        tick();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        need = op[1] ? int'(DIV_N) : int'(MULT_N);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            check("stall_busy", {31'd0, stall_md}, {31'd0, din});
            n++;
            tick();
        end
        check("busy_len", 32'(n), 32'(need));
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("hi", hi_out, e.hi);
            check("lo", lo_out, e.lo);
        end
        check("busy_done", {31'd0, busy}, 32'd0);
        md_in_d = 1'b0;
        #1;
        check("stall_idle", {31'd0, stall_md}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        total = 0; bad = 0; m_hi = '0; m_lo = '0;
        reset = 1'b1; start = 1'b0; md_op = 2'b00; hi_we = 1'b0; lo_we = 1'b0;
        rs_val = '0; rt_val = '0; md_in_d = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        check("rst_stall", {31'd0, stall_md}, 32'd0);

        // mthi+mtlo together, then mtlo alone
        hi_we = 1'b1; lo_we = 1'b1; rs_val = 32'h1234_5678;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthilo_hi", hi_out, 32'h1234_5678);
        check("mthilo_lo", lo_out, 32'h1234_5678);
        lo_we = 1'b1; rs_val = 32'h9ABC_DEF0;
        tick();
        lo_we = 1'b0;
        check("mtlo_hi", hi_out, 32'h1234_5678);
        check("mtlo_lo", lo_out, 32'h9ABC_DEF0);
        m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;

        // divu 7/0 issued alongside mthi/mtlo: writes dropped, HI/LO unchanged
        do_op(2'b11, 32'd7, 32'd0, 1'b0, 1'b1);

        do_op(2'b00, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
        check("mult_hi_const", hi_out, 32'hFFFF_FFFF);
        check("mult_lo_const", lo_out, 32'hFFFF_FFFE);
        do_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        check("multu_hi_const", hi_out, 32'h0000_0001);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        check("div_lo_const", lo_out, 32'hFFFF_FFFD);
        check("div_hi_const", hi_out, 32'hFFFF_FFFF);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("ovf_lo_const", lo_out, 32'h8000_0000);
        check("ovf_hi_const", hi_out, 32'h0000_0000);
        do_op(2'b11, 32'hFFFF_FFF9, 32'd5, 1'b0, 1'b0);
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_op(2'(i % 4), ra, rb, 1'(i % 2), 1'b0);
        end

        // reset during cycle 3 of a div aborts it
        start = 1'b1; md_op = 2'b10; rs_val = 32'd100; rt_val = 32'd7;
        tick();
        start = 1'b0;
        tick(); tick();
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi_out, 32'd0);
        check("abort_lo", lo_out, 32'd0);
        repeat (DIV_N + 4) tick();
        check("abort_late_hi", hi_out, 32'd0);
        check("abort_late_lo", lo_out, 32'd0);
        check("abort_late_busy", {31'd0, busy}, 32'd0);

        // reset wins over mthi and start in the same cycle
        reset = 1'b1; hi_we = 1'b1; start = 1'b1; md_op = 2'b00; rs_val = 32'hDEAD_BEEF;
        tick();
        reset = 1'b0; hi_we = 1'b0; start = 1'b0;
        check("rstprio_hi", hi_out, 32'd0);
        check("rstprio_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
